// File: rtl/uart_bram_loader.sv
// rtl/uart_bram_loader.sv - 8N1 UART receiver packing bytes into 32-bit BRAM writes (optional LOADER_CHECKSUM_EN)
module uart_bram_loader #(
    parameter int BOARD_CK   = 32000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  clr,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           din,
    output logic                  byte_valid,
    output logic [7:0]            rx_byte,
    output logic                  frame_err,
    output logic                  wrapped,
    output logic                  busy
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam int CLKS_PER_BIT = BOARD_CK / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [1:0]    lane;
    logic          word_done;

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receive FSM, byte packing into din and the BRAM write/address sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            lane       <= '0;
            word_done  <= 1'b0;
            we         <= 1'b0;
            addr       <= '0;
            din        <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            word_done  <= 1'b0;
            // A clear while a completed word is pending drops that word too.
            we         <= word_done & ~clr;

            // The cycle after the write pulse advances to the next word slot.
            if (we) begin
                addr <= addr + 1'b1;
                lane <= '0;
                if (addr == '1) begin
                    wrapped <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (!clr) begin
                                byte_valid               <= 1'b1;
                                rx_byte                  <= shift;
                                din[{lane, 3'b000} +: 8] <= shift;
                                // Lane stays at 3 until the write retires, then resets.
                                if (lane == 2'd3) begin
                                    word_done <= 1'b1;
                                end else begin
                                    lane <= lane + 1'b1;
                                end
                            end
                        end else begin
                            frame_err <= 1'b1;
                            lane      <= '0;
                            state     <= WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Clear wins over everything above, but leaves the receiver running.
            if (clr) begin
                lane      <= '0;
                addr      <= '0;
                frame_err <= 1'b0;
                wrapped   <= 1'b0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every word written, so the host can confirm the image.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (clr) begin
            checksum <= '0;
        end else if (we) begin
            checksum <= checksum ^ din;
        end
    end
`endif

    assign busy = (state != IDLE) || (lane != 2'd0) || word_done || we;

endmodule
